// File: rtl/acc_cpu.sv
// acc_cpu: minimal accumulator CPU with a shared program/data RAM.
//
// Instruction word = {opcode[INSTR_SIZE], operand[ADDRESS_WIDTH]}.
// Each instruction runs T1 (MAR<=PC), T2 (fetch, PC++), then T3..T5
// depending on the opcode; HLT parks the machine in HALT until rst.
//
// Ports:
//   clk        sole clock, all state changes on its rising edge
//   rst        synchronous active-high reset; RAM is preserved
//   prog_we    RAM write strobe, only honoured while rst=1
//   prog_addr  RAM write address
//   prog_data  RAM write data
//   out_data   registered output port, holds the last OUT value
//   out_valid  one-cycle pulse following each OUT
//   halted     high while in HALT
//   carry      carry flag (for SUB: 1 = no borrow)
//   zero       zero flag
//
// Build option: define ACC_CPU_SUB_EN to enable SUB (0011), JZ (1001)
// and the zero flag. Without it those opcodes run as 3-cycle NOPs and
// zero is tied low.
module acc_cpu #(
    parameter int WIDTH      = 8,
    parameter int INSTR_SIZE = 4,
    parameter int OUT_WIDTH  = 5,
    localparam int ADDRESS_WIDTH = WIDTH - INSTR_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [ADDRESS_WIDTH-1:0] prog_addr,
    input  logic [WIDTH-1:0]         prog_data,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    output logic                     halted,
    output logic                     carry,
    output logic                     zero
);

    localparam logic [2:0] T1   = 3'd0;
    localparam logic [2:0] T2   = 3'd1;
    localparam logic [2:0] T3   = 3'd2;
    localparam logic [2:0] T4   = 3'd3;
    localparam logic [2:0] T5   = 3'd4;
    localparam logic [2:0] HALT = 3'd5;

    localparam logic [INSTR_SIZE-1:0] OP_LDA = INSTR_SIZE'(4'h1);
    localparam logic [INSTR_SIZE-1:0] OP_ADD = INSTR_SIZE'(4'h2);
    localparam logic [INSTR_SIZE-1:0] OP_STA = INSTR_SIZE'(4'h4);
    localparam logic [INSTR_SIZE-1:0] OP_OUT = INSTR_SIZE'(4'h5);
    localparam logic [INSTR_SIZE-1:0] OP_JMP = INSTR_SIZE'(4'h6);
    localparam logic [INSTR_SIZE-1:0] OP_LDI = INSTR_SIZE'(4'h7);
    localparam logic [INSTR_SIZE-1:0] OP_JC  = INSTR_SIZE'(4'h8);
    localparam logic [INSTR_SIZE-1:0] OP_HLT = INSTR_SIZE'(4'hF);
`ifdef ACC_CPU_SUB_EN
    localparam logic [INSTR_SIZE-1:0] OP_SUB = INSTR_SIZE'(4'h3);
    localparam logic [INSTR_SIZE-1:0] OP_JZ  = INSTR_SIZE'(4'h9);
`endif

    logic [WIDTH-1:0]         ram [0:(1 << ADDRESS_WIDTH)-1];
    logic [2:0]               state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] mar;
    logic [WIDTH-1:0]         ir;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     carry_r;
    logic [WIDTH:0]           sum;

    logic [INSTR_SIZE-1:0]    op;
    logic [ADDRESS_WIDTH-1:0] operand;

    assign op      = ir[WIDTH-1:ADDRESS_WIDTH];
    assign operand = ir[ADDRESS_WIDTH-1:0];

    // Subtraction is A + ~B + 1 so the carry-out doubles as "no borrow".
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
`ifdef ACC_CPU_SUB_EN
        if (op == OP_SUB)
            sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
`endif
    end

`ifdef ACC_CPU_SUB_EN
    logic zero_r;
    assign zero = zero_r;
`else
    assign zero = 1'b0;
`endif

    assign carry  = carry_r;
    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            // RAM survives reset; loading is only possible from here.
            state     <= T1;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            carry_r   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef ACC_CPU_SUB_EN
            zero_r    <= 1'b0;
`endif
            if (prog_we)
                ram[prog_addr] <= prog_data;
        end else begin
            out_valid <= 1'b0;
            case (state)
                T1: begin
                    mar   <= pc;
                    state <= T2;
                end
                T2: begin
                    ir    <= ram[mar];
                    pc    <= pc + 1'b1;   // wraps at the top of memory
                    state <= T3;
                end
                T3: begin
                    state <= T1;
                    case (op)
                        OP_JMP: pc <= operand;
                        OP_JC:  if (carry_r) pc <= operand;
`ifdef ACC_CPU_SUB_EN
                        OP_JZ:  if (zero_r) pc <= operand;
                        OP_SUB: state <= T4;
`endif
                        OP_LDI: a <= WIDTH'(operand);
                        OP_OUT: begin
                            out_data  <= a[OUT_WIDTH-1:0];
                            out_valid <= 1'b1;
                        end
                        OP_LDA, OP_STA, OP_ADD: state <= T4;
                        OP_HLT: state <= HALT;
                        default: ;
                    endcase
                end
                T4: begin
                    state <= T1;
                    case (op)
                        OP_LDA: a <= ram[operand];
                        OP_STA: ram[operand] <= a;
                        default: begin   // ADD / SUB fetch their operand
                            b     <= ram[operand];
                            state <= T5;
                        end
                    endcase
                end
                T5: begin
                    a       <= sum[WIDTH-1:0];
                    carry_r <= sum[WIDTH];
`ifdef ACC_CPU_SUB_EN
                    zero_r  <= (sum[WIDTH-1:0] == '0);
`endif
                    state   <= T1;
                end
                HALT: ;
                default: state <= T1;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench for acc_cpu (WIDTH=8, INSTR_SIZE=4, OUT_WIDTH=5).
// An instruction-level model predicts, per cycle, the tuple
// {out_valid, out_data, halted, carry, zero}; directed programs add
// constant checks on top of the model comparison.
module tb_acc_cpu;

`ifdef ACC_CPU_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int MAXC = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [4:0] out_data;
    logic       out_valid;
    logic       halted;
    logic       carry;
    logic       zero;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem   [16];
    logic [8:0] exp_t [MAXC];
    logic [8:0] act_t [MAXC];

    acc_cpu #(.WIDTH(8), .INSTR_SIZE(4), .OUT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid),
        .halted(halted), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: state changes land at instruction end.
    task automatic model(input int n);
        logic [7:0] m [16];
        int pc, cyc, len;
        logic [7:0] a, ins;
        logic [8:0] t;
        logic [4:0] od;
        logic [3:0] op, opd;
        logic c, z, hlt, pv;
        for (int i = 0; i < 16; i++) m[i] = mem[i];
        pc = 0; a = 0; c = 0; z = 0; hlt = 0; pv = 0; od = 0; cyc = 0;
        while (cyc < n) begin
            if (hlt) begin
                exp_t[cyc] = {pv, od, 1'b1, c, z};
                pv = 0; cyc++;
            end else begin
                ins = m[pc]; pc = (pc + 1) % 16;
                op = ins[7:4]; opd = ins[3:0];
                len = 3;
                if (op == 1 || op == 4) len = 4;
                if (op == 2 || (SUB_EN && op == 3)) len = 5;
                for (int k = 0; k < len && cyc < n; k++) begin
                    exp_t[cyc] = {pv, od, 1'b0, c, z};
                    pv = 0; cyc++;
                end
                case (op)
                    4'h1: a = m[opd];
                    4'h2: begin t = {1'b0, a} + {1'b0, m[opd]}; c = t[8]; a = t[7:0]; z = (a == 0) && SUB_EN; end
                    4'h3: if (SUB_EN) begin
                        t = {1'b0, a} + {1'b0, ~m[opd]} + 9'd1; c = t[8]; a = t[7:0]; z = (a == 0);
                    end
                    4'h4: m[opd] = a;
                    4'h5: begin od = a[4:0]; pv = 1; end
                    4'h6: pc = opd;
                    4'h7: a = {4'h0, opd};
                    4'h8: if (c) pc = opd;
                    4'h9: if (SUB_EN && z) pc = opd;
                    4'hF: hlt = 1;
                    default: ;
                endcase
            end
        end
    endtask

    // Hold reset while writing mem[lo..hi]; returns at the start of cycle 0.
    task automatic load(input int lo, input int hi);
        rst = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = mem[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Capture n cycles of outputs; noise drives prog_we while running.
    task automatic run_dut(input int n, input bit noise);
        for (int c = 0; c < n; c++) begin
            if (noise) begin
                prog_we = 1'($urandom_range(0, 1));
                prog_addr = 4'($urandom); prog_data = 8'($urandom);
            end
            @(negedge clk);
            act_t[c] = {out_valid, out_data, halted, carry, zero};
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    function automatic void clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, halted, carry, zero} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", {out_valid, out_data, halted, carry, zero}, 9'h0);
        end
    endtask

    task automatic test_out_timing();
        int pulses;
        clear_mem(); mem[0] = 8'h75; mem[1] = 8'h50; mem[2] = 8'hF0;
        load(0, 15); run_dut(14, 0); model(14);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL out_timing cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
            if (act_t[c][8]) pulses++;
        end
        checks++;
        if (act_t[6][8:3] !== {1'b1, 5'd5}) begin errors++; $display("FAIL out_cycle6 got %h exp %h", act_t[6][8:3], {1'b1, 5'd5}); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL out_pulses got %0d exp 1", pulses); end
        checks++;
        if ({act_t[8][2], act_t[9][2], act_t[13][2]} !== 3'b011) begin
            errors++; $display("FAIL halt_timing got %b exp 011", {act_t[8][2], act_t[9][2], act_t[13][2]});
        end
    endtask

    task automatic test_add();
        clear_mem(); mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h50; mem[3] = 8'hF0;
        mem[14] = 8'hF0; mem[15] = 8'h20;
        load(0, 15); run_dut(25, 0); model(25);
        for (int c = 0; c < 25; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL add cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
        end
        checks++;
        if (act_t[24][7:0] !== {5'h10, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_result got %h exp %h", act_t[24][7:0], {5'h10, 3'b110});
        end
    endtask

    task automatic test_sub_jz();
        clear_mem();
        if (SUB_EN) begin
            mem[0] = 8'h77; mem[1] = 8'h4F; mem[2] = 8'h3F; mem[3] = 8'h96; mem[4] = 8'h50;
            mem[5] = 8'hF0; mem[6] = 8'h73; mem[7] = 8'h50; mem[8] = 8'hF0;
        end else begin
            // 0011 must behave as a 3-cycle NOP, zero stays low
            mem[0] = 8'h77; mem[1] = 8'h3F; mem[2] = 8'h50; mem[3] = 8'hF0;
        end
        load(0, 15); run_dut(35, 0); model(35);
        for (int c = 0; c < 35; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL sub_jz cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
        end
        checks++;
        if (SUB_EN) begin
            if (act_t[34][7:0] !== {5'd3, 1'b1, 1'b1, 1'b1}) begin
                errors++; $display("FAIL sub_jz_result got %h exp %h", act_t[34][7:0], {5'd3, 3'b111});
            end
        end else if (act_t[34][7:0] !== {5'd7, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_nop_result got %h exp %h", act_t[34][7:0], {5'd7, 3'b100});
        end
    endtask

    task automatic test_jc_not_taken();
        clear_mem(); mem[0] = 8'h71; mem[1] = 8'h85; mem[2] = 8'h50; mem[3] = 8'hF0;
        mem[5] = 8'h7A; mem[6] = 8'h50; mem[7] = 8'hF0;
        load(0, 15); run_dut(20, 0); model(20);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL jc cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
        end
        checks++;
        if (act_t[19][7:3] !== 5'd1) begin errors++; $display("FAIL jc_result got %h exp 01", act_t[19][7:3]); end
    endtask

    // JMP 14; 14: LDI 9; 15: STA 0 -> PC wraps to 0, runs NOP 9, OUT, HLT.
    task automatic test_pc_wrap();
        clear_mem(); mem[0] = 8'h6E; mem[1] = 8'h50; mem[2] = 8'hF0;
        mem[14] = 8'h79; mem[15] = 8'h40;
        load(0, 15); run_dut(25, 0); model(25);
        for (int c = 0; c < 25; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL wrap cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
        end
        checks++;
        if ({act_t[16][8:3], act_t[19][2]} !== {1'b1, 5'd9, 1'b1}) begin
            errors++; $display("FAIL wrap_result got %h exp %h", {act_t[16][8:3], act_t[19][2]}, {1'b1, 5'd9, 1'b1});
        end
    endtask

    task automatic test_reset_abort();
        // LDA 14, ADD 15, OUT, ADD 15 (aborted in T4), OUT, HLT
        clear_mem(); mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'h50; mem[3] = 8'h2F;
        mem[4] = 8'h50; mem[5] = 8'hF0; mem[14] = 8'hF0; mem[15] = 8'h20;
        load(0, 15); run_dut(15, 0);
        checks++;
        if (act_t[14][7:0] !== {5'h10, 3'b010}) begin errors++; $display("FAIL pre_abort got %h exp %h", act_t[14][7:0], {5'h10, 3'b010}); end
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        run_dut(40, 0); model(40);
        checks++;
        if (act_t[0] !== 9'h0) begin errors++; $display("FAIL abort_clear got %h exp 000", act_t[0]); end
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (act_t[c] !== exp_t[c]) begin errors++; $display("FAIL abort_rerun cyc %0d got %h exp %h", c, act_t[c], exp_t[c]); end
        end
        // STA aborted in T4 must leave RAM[15] untouched.
        clear_mem(); mem[0] = 8'h77; mem[1] = 8'h4F; mem[2] = 8'hF0; mem[15] = 8'h2A;
        load(0, 15); run_dut(6, 0);
        mem[0] = 8'h1F; mem[1] = 8'h50; mem[2] = 8'hF0;
        load(0, 2); run_dut(15, 0); model(15);
        checks++;
        if (act_t[14][7:3] !== 5'h0A) begin errors++; $display("FAIL sta_abort got %h exp 0a", act_t[14][7:3]); end
    endtask

    task automatic test_random();
        logic [3:0] ops [12];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hF};
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = {ops[$urandom_range(0, 11)], 4'($urandom)};
                if (mem[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) mem[i][7:4] = 4'h2;
            end
            load(0, 15); run_dut(150, 1); model(150);
            for (int c = 0; c < 150; c++) begin
                checks++;
                if (act_t[c] !== exp_t[c]) begin
                    errors++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, c, act_t[c], exp_t[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_timing();
        test_add();
        test_sub_jz();
        test_jc_not_taken();
        test_pc_wrap();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
